pim_dma_ctrl: RTL

- DMA engine that executes the core's DMA instructions, moving 32-bit words between data memory and one of four PIM macros.
- Sits directly downstream of the core's EX stage.
  - Consumes the core's dma_en/funct3/sel_pim/size/mem_addr command outputs.
  - Drives the core's dma_busy input, which holds the core stalled for the whole transfer.
- Masters the data-memory port through the same req/gnt arbiter the core uses.

---
 rtl/pim_dma_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/pim_dma_ctrl.sv
// pim_dma_ctrl
// DMA engine for the core's DMA instructions. It moves 32-bit words between
// data memory and one of NUM_PIM PIM macros, one word at a time, and holds the
// core stalled through dma_busy_o until the transfer is finished.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dma_*_i                command from core EX (strobe, direction, select,
//                          byte size, memory base address)
//   dma_busy_o             high from the cycle after acceptance through DONE
//   mem_*                  data-memory master port (req/gnt handshake)
//   pim_*                  PIM macro port (write valid/ready, read req/valid)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no transfer, waiting for a valid command
// MEM_RD   | memory read request for word i, held until grant
// MEM_WAIT | memory read data arrives, captured into the word buffer
// PIM_WR   | word buffer offered to the PIM, held until ready
// PIM_RD   | one-cycle PIM read request for word i
// PIM_WAIT | waiting for PIM read data, captured into the word buffer
// MEM_WR   | memory write of the word buffer, held until grant
// DONE     | last word finished, one more busy cycle before IDLE
//
// Outputs are registered: the output flops are loaded from the decode of the
// next state, so every output lines up with the state it belongs to.

module pim_dma_ctrl #(
   parameter int XLEN    = 32,
   parameter int NUM_PIM = 4,
   parameter int SIZE_W  = 13,
   parameter int PIM_AW  = 11
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                dma_en_i,
   input  logic [2:0]          dma_funct3_i,
   input  logic [NUM_PIM-1:0]  dma_sel_pim_i,
   input  logic [SIZE_W-1:0]   dma_size_i,
   input  logic [XLEN-1:0]     dma_mem_addr_i,
   output logic                dma_busy_o,
   output logic                mem_req_o,
   input  logic                mem_gnt_i,
   output logic [XLEN-1:0]     mem_addr_o,
   output logic [XLEN-1:0]     mem_wr_data_o,
   output logic [3:0]          mem_size_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   input  logic [XLEN-1:0]     mem_rd_data_i,
   output logic [NUM_PIM-1:0]  pim_sel_o,
   output logic [PIM_AW-1:0]   pim_addr_o,
   output logic                pim_wr_valid_o,
   input  logic                pim_wr_ready_i,
   output logic [XLEN-1:0]     pim_wr_data_o,
   output logic                pim_rd_req_o,
   input  logic                pim_rd_valid_i,
   input  logic [XLEN-1:0]     pim_rd_data_i
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MEM_RD   = 3'd1,
      MEM_WAIT = 3'd2,
      PIM_WR   = 3'd3,
      PIM_RD   = 3'd4,
      PIM_WAIT = 3'd5,
      MEM_WR   = 3'd6,
      DONE     = 3'd7
   } state_e;

   state_e              state_q, state_d;
   logic [PIM_AW-1:0]   cnt_q, cnt_d;
   logic [PIM_AW-1:0]   num_q, num_d;
   logic [XLEN-3:0]     base_q, base_d;
   logic [NUM_PIM-1:0]  sel_q, sel_d;
   logic [XLEN-1:0]     buf_q, buf_d;

   logic                busy_q, busy_d;
   logic                mem_req_q, mem_req_d;
   logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]     mem_wr_data_q, mem_wr_data_d;
   logic [3:0]          mem_size_q, mem_size_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [NUM_PIM-1:0]  pim_sel_q, pim_sel_d;
   logic [PIM_AW-1:0]   pim_addr_q, pim_addr_d;
   logic                pim_wr_valid_q, pim_wr_valid_d;
   logic [XLEN-1:0]     pim_wr_data_q, pim_wr_data_d;
   logic                pim_rd_req_q, pim_rd_req_d;

   logic [PIM_AW-1:0]   cnt_inc;
   logic                last_word;
   logic                cmd_ok;
   logic [XLEN-3:0]     word_addr_d;
   logic                unused_lsbs;

   // Byte-offset bits are dropped: transfers are word aligned.
   assign unused_lsbs = ^{dma_size_i[1:0], dma_mem_addr_i[1:0]};

   assign cnt_inc   = cnt_q + PIM_AW'(1);
   assign last_word = (cnt_inc == num_q);
   assign cmd_ok    = dma_en_i && (dma_funct3_i[2:1] == 2'b00)
                      && (dma_size_i[SIZE_W-1:2] != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      base_d  = base_q;
      sel_d   = sel_q;
      buf_d   = buf_q;

      case (state_q)
         IDLE: begin
            if (cmd_ok) begin
               base_d  = dma_mem_addr_i[XLEN-1:2];
               sel_d   = dma_sel_pim_i;
               num_d   = dma_size_i[SIZE_W-1:2];
               cnt_d   = '0;
               state_d = dma_funct3_i[0] ? PIM_RD : MEM_RD;
            end
         end
         MEM_RD: begin
            if (mem_gnt_i) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            buf_d   = mem_rd_data_i;
            state_d = PIM_WR;
         end
         PIM_WR: begin
            if (pim_wr_ready_i) begin
               cnt_d   = cnt_inc;
               state_d = last_word ? DONE : MEM_RD;
            end
         end
         PIM_RD: begin
            state_d = PIM_WAIT;
         end
         PIM_WAIT: begin
            if (pim_rd_valid_i) begin
               buf_d   = pim_rd_data_i;
               state_d = MEM_WR;
            end
         end
         MEM_WR: begin
            if (mem_gnt_i) begin
               cnt_d   = cnt_inc;
               state_d = last_word ? DONE : PIM_RD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Word address base + i, wrapping at the top of the address space.
      word_addr_d = base_d + (XLEN-2)'(cnt_d);

      busy_d         = (state_d != IDLE);
      mem_req_d      = (state_d == MEM_RD) || (state_d == MEM_WR);
      mem_read_d     = (state_d == MEM_RD);
      mem_write_d    = (state_d == MEM_WR);
      mem_size_d     = mem_req_d ? 4'b1111 : 4'b0000;
      mem_addr_d     = mem_req_d ? {word_addr_d, 2'b00} : '0;
      mem_wr_data_d  = (state_d == MEM_WR) ? buf_d : '0;
      pim_sel_d      = busy_d ? sel_d : '0;
      pim_wr_valid_d = (state_d == PIM_WR);
      pim_rd_req_d   = (state_d == PIM_RD);
      pim_addr_d     = (pim_wr_valid_d || pim_rd_req_d) ? cnt_d : '0;
      pim_wr_data_d  = pim_wr_valid_d ? buf_d : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         num_q          <= '0;
         base_q         <= '0;
         sel_q          <= '0;
         buf_q          <= '0;
         busy_q         <= 1'b0;
         mem_req_q      <= 1'b0;
         mem_addr_q     <= '0;
         mem_wr_data_q  <= '0;
         mem_size_q     <= '0;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         pim_sel_q      <= '0;
         pim_addr_q     <= '0;
         pim_wr_valid_q <= 1'b0;
         pim_wr_data_q  <= '0;
         pim_rd_req_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         num_q          <= num_d;
         base_q         <= base_d;
         sel_q          <= sel_d;
         buf_q          <= buf_d;
         busy_q         <= busy_d;
         mem_req_q      <= mem_req_d;
         mem_addr_q     <= mem_addr_d;
         mem_wr_data_q  <= mem_wr_data_d;
         mem_size_q     <= mem_size_d;
         mem_read_q     <= mem_read_d;
         mem_write_q    <= mem_write_d;
         pim_sel_q      <= pim_sel_d;
         pim_addr_q     <= pim_addr_d;
         pim_wr_valid_q <= pim_wr_valid_d;
         pim_wr_data_q  <= pim_wr_data_d;
         pim_rd_req_q   <= pim_rd_req_d;
      end
   end

   assign dma_busy_o     = busy_q;
   assign mem_req_o      = mem_req_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_wr_data_o  = mem_wr_data_q;
   assign mem_size_o     = mem_size_q;
   assign mem_read_o     = mem_read_q;
   assign mem_write_o    = mem_write_q;
   assign pim_sel_o      = pim_sel_q;
   assign pim_addr_o     = pim_addr_q;
   assign pim_wr_valid_o = pim_wr_valid_q;
   assign pim_wr_data_o  = pim_wr_data_q;
   assign pim_rd_req_o   = pim_rd_req_q;

endmodule
